// File: rtl/cajero_automatico_param_if.sv
`default_nettype none
// ============================================================================
// cajero_automatico_param_if
//   Front-end / balance-store signal bundle for the ATM transaction controller.
//   Rev 1.0
// ============================================================================
interface cajero_automatico_param_if #(
  parameter int PIN_DIGITOS = 4,
  parameter int MONTO_W     = 32,
  parameter int BALANCE_W   = 64
);
  logic                     tarjeta_recibida;
  logic                     digito_stb;
  logic [3:0]               digito;
  logic [4*PIN_DIGITOS-1:0] pin_correcto;
  logic                     tipo_trans;
  logic                     monto_stb;
  logic [MONTO_W-1:0]       monto;
  logic [BALANCE_W-1:0]     balance_inicial;
  logic                     dia_nuevo;

  logic                     pin_incorrecto;
  logic                     advertencia;
  logic                     bloqueo;
  logic [BALANCE_W-1:0]     balance_actualizado;
  logic                     balance_stb;
  logic                     entregar_dinero;
  logic                     fondos_insuficientes;
  logic                     limite_excedido;
  logic                     timeout;

  modport master (
    output tarjeta_recibida, digito_stb, digito, pin_correcto, tipo_trans,
           monto_stb, monto, balance_inicial, dia_nuevo,
    input  pin_incorrecto, advertencia, bloqueo, balance_actualizado,
           balance_stb, entregar_dinero, fondos_insuficientes,
           limite_excedido, timeout
  );

  modport slave (
    input  tarjeta_recibida, digito_stb, digito, pin_correcto, tipo_trans,
           monto_stb, monto, balance_inicial, dia_nuevo,
    output pin_incorrecto, advertencia, bloqueo, balance_actualizado,
           balance_stb, entregar_dinero, fondos_insuficientes,
           limite_excedido, timeout
  );
endinterface
`default_nettype wire

// File: rtl/cajero_automatico_param.sv
`default_nettype none
// ============================================================================
// cajero_automatico_param
//   ATM session controller: card-in, PIN attempts with lockout, deposits and
//   withdrawals with a daily withdrawal limit and inactivity timeout.
//   Rev 1.0
// ============================================================================
module cajero_automatico_param #(
  parameter int PIN_DIGITOS    = 4,
  parameter int MAX_INTENTOS   = 3,
  parameter int MONTO_W        = 32,
  parameter int BALANCE_W      = 64,
  parameter int LIMITE_DIARIO  = 100000,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input wire clk,
  input wire reset,
  cajero_automatico_param_if.slave cajero
);
  localparam int PIN_W  = 4 * PIN_DIGITOS;
  localparam int DIG_W  = $clog2(PIN_DIGITOS + 1);
  localparam int INT_W  = $clog2(MAX_INTENTOS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CICLOS + 1);
  localparam int LIM_W  = $clog2(LIMITE_DIARIO + 1);
  localparam int ACUM_W = ((LIM_W > MONTO_W) ? LIM_W : MONTO_W) + 1;

  typedef enum logic [1:0] {
    ESPERA_TARJETA = 2'd0,
    ESPERA_PIN     = 2'd1,
    ESPERA_MONTO   = 2'd2,
    BLOQUEADO      = 2'd3
  } estado_t;

  estado_t              r_estado, w_estado;
  logic [DIG_W-1:0]     r_digitos, w_digitos;
  logic [PIN_W-1:0]     r_pin, w_pin;
  logic [INT_W-1:0]     r_intentos, w_intentos;
  logic [TMR_W-1:0]     r_timer, w_timer;
  logic [ACUM_W-1:0]    r_acum, w_acum;
  logic [BALANCE_W-1:0] r_balance, w_balance;
  logic                 r_pin_incorrecto, w_pin_incorrecto;
  logic                 r_advertencia, w_advertencia;
  logic                 r_bloqueo, w_bloqueo;
  logic                 r_balance_stb, w_balance_stb;
  logic                 r_entregar, w_entregar;
  logic                 r_fondos, w_fondos;
  logic                 r_limite, w_limite;
  logic                 r_timeout, w_timeout;

  logic [BALANCE_W-1:0] w_monto_ext;
  logic [BALANCE_W:0]   w_suma;
  logic [BALANCE_W-1:0] w_resta;
  logic [ACUM_W-1:0]    w_acum_base;
  logic [ACUM_W-1:0]    w_acum_suma;
  logic [PIN_W-1:0]     w_pin_shift;
  logic [INT_W-1:0]     w_intentos_inc;
  logic                 w_ultimo_dig;
  logic                 w_expira;

  assign w_monto_ext    = BALANCE_W'(cajero.monto);
  assign w_suma         = {1'b0, cajero.balance_inicial} + {1'b0, w_monto_ext};
  assign w_resta        = cajero.balance_inicial - w_monto_ext;
  // A new-day pulse clears the accumulator before any same-cycle commit adds to it.
  assign w_acum_base    = cajero.dia_nuevo ? '0 : r_acum;
  assign w_acum_suma    = w_acum_base + ACUM_W'(cajero.monto);
  assign w_pin_shift    = (r_pin << 4) | PIN_W'(cajero.digito);
  assign w_intentos_inc = r_intentos + INT_W'(1);
  assign w_ultimo_dig   = (r_digitos == DIG_W'(PIN_DIGITOS - 1));
  assign w_expira       = (r_timer == TMR_W'(TIMEOUT_CICLOS - 1));

  always_comb begin
    w_estado         = r_estado;
    w_digitos        = r_digitos;
    w_pin            = r_pin;
    w_intentos       = r_intentos;
    w_timer          = r_timer;
    w_acum           = w_acum_base;
    w_balance        = r_balance;
    w_advertencia    = r_advertencia;
    w_pin_incorrecto = 1'b0;
    w_balance_stb    = 1'b0;
    w_entregar       = 1'b0;
    w_fondos         = 1'b0;
    w_limite         = 1'b0;
    w_timeout        = 1'b0;

    case (r_estado)
      ESPERA_TARJETA: begin
        if (cajero.tarjeta_recibida) begin
          w_estado  = ESPERA_PIN;
          w_digitos = '0;
          w_pin     = '0;
          w_timer   = '0;
        end
      end

      ESPERA_PIN: begin
        if (cajero.digito_stb) begin
          w_timer = '0;
          w_pin   = w_pin_shift;
          if (!w_ultimo_dig) begin
            w_digitos = r_digitos + DIG_W'(1);
          end else begin
            w_digitos = '0;
            if (w_pin_shift == cajero.pin_correcto) begin
              w_estado      = ESPERA_MONTO;
              w_intentos    = '0;
              w_advertencia = 1'b0;
            end else begin
              w_intentos       = w_intentos_inc;
              w_pin_incorrecto = 1'b1;
              if (w_intentos_inc >= INT_W'(MAX_INTENTOS)) begin
                w_estado = BLOQUEADO;
              end else if (w_intentos_inc == INT_W'(MAX_INTENTOS - 1)) begin
                w_advertencia = 1'b1;
              end
            end
          end
        end else if (w_expira) begin
          w_timeout     = 1'b1;
          w_estado      = ESPERA_TARJETA;
          w_timer       = '0;
          w_digitos     = '0;
          w_intentos    = '0;
          w_advertencia = 1'b0;
        end else begin
          w_timer = r_timer + TMR_W'(1);
        end
      end

      ESPERA_MONTO: begin
        if (cajero.monto_stb) begin
          w_estado = ESPERA_TARJETA;
          w_timer  = '0;
          if (!cajero.tipo_trans) begin
            w_balance     = w_suma[BALANCE_W] ? '1 : w_suma[BALANCE_W-1:0];
            w_balance_stb = 1'b1;
          end else if (w_monto_ext > cajero.balance_inicial) begin
            w_fondos = 1'b1;
          end else if (w_acum_suma > ACUM_W'(LIMITE_DIARIO)) begin
            w_limite = 1'b1;
          end else begin
            w_balance     = w_resta;
            w_balance_stb = 1'b1;
            w_entregar    = 1'b1;
            w_acum        = w_acum_suma;
          end
        end else if (w_expira) begin
          w_timeout     = 1'b1;
          w_estado      = ESPERA_TARJETA;
          w_timer       = '0;
          w_intentos    = '0;
          w_advertencia = 1'b0;
        end else begin
          w_timer = r_timer + TMR_W'(1);
        end
      end

      BLOQUEADO: begin
        w_estado = BLOQUEADO;
      end

      default: begin
        w_estado = ESPERA_TARJETA;
      end
    endcase

    w_bloqueo = (w_estado == BLOQUEADO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado         <= ESPERA_TARJETA;
      r_digitos        <= '0;
      r_pin            <= '0;
      r_intentos       <= '0;
      r_timer          <= '0;
      r_acum           <= '0;
      r_balance        <= '0;
      r_pin_incorrecto <= 1'b0;
      r_advertencia    <= 1'b0;
      r_bloqueo        <= 1'b0;
      r_balance_stb    <= 1'b0;
      r_entregar       <= 1'b0;
      r_fondos         <= 1'b0;
      r_limite         <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_estado         <= w_estado;
      r_digitos        <= w_digitos;
      r_pin            <= w_pin;
      r_intentos       <= w_intentos;
      r_timer          <= w_timer;
      r_acum           <= w_acum;
      r_balance        <= w_balance;
      r_pin_incorrecto <= w_pin_incorrecto;
      r_advertencia    <= w_advertencia;
      r_bloqueo        <= w_bloqueo;
      r_balance_stb    <= w_balance_stb;
      r_entregar       <= w_entregar;
      r_fondos         <= w_fondos;
      r_limite         <= w_limite;
      r_timeout        <= w_timeout;
    end
  end

  assign cajero.pin_incorrecto       = r_pin_incorrecto;
  assign cajero.advertencia          = r_advertencia;
  assign cajero.bloqueo              = r_bloqueo;
  assign cajero.balance_actualizado  = r_balance;
  assign cajero.balance_stb          = r_balance_stb;
  assign cajero.entregar_dinero      = r_entregar;
  assign cajero.fondos_insuficientes = r_fondos;
  assign cajero.limite_excedido      = r_limite;
  assign cajero.timeout              = r_timeout;

endmodule
`default_nettype wire

// File: doc/cajero_automatico_param.md
Name: cajero_automatico_param

Overview:
Parametrised ATM transaction controller, the next generation of the fixed 4-digit / 64-bit cashier FSM. It handles card-in, PIN entry with a configurable attempt count, and deposits and withdrawals against an external balance. New over the previous generation: configurable PIN length, data widths and attempt limit; an explicit amount strobe; an inactivity timeout; and a cumulative daily withdrawal limit. It sits between the card/keypad front end and the account-balance store.

Parameters:
PIN_DIGITOS, 4, number of BCD digits in the PIN (1..8)
MAX_INTENTOS, 3, wrong-PIN attempts that trigger lockout (>=2)
MONTO_W, 32, amount width in bits (MONTO_W <= BALANCE_W)
BALANCE_W, 64, balance width in bits
LIMITE_DIARIO, 100000, maximum cumulative withdrawals between dia_nuevo pulses
TIMEOUT_CICLOS, 1000, idle cycles before a session is aborted (counter width = $clog2(TIMEOUT_CICLOS+1))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tarjeta_recibida  input  1  card inserted (level; sampled only in ESPERA_TARJETA)
digito_stb  input  1  one-cycle strobe: digito valid
digito  input  4  PIN digit
pin_correcto  input  4*PIN_DIGITOS  stored PIN, first digit in MSB nibble
tipo_trans  input  1  0 = deposit, 1 = withdrawal (sampled with monto_stb)
monto_stb  input  1  one-cycle strobe: monto/tipo_trans valid
monto  input  MONTO_W  transaction amount
balance_inicial  input  BALANCE_W  current account balance
dia_nuevo  input  1  one-cycle pulse: clears the daily withdrawal accumulator
pin_incorrecto  output  1  one-cycle pulse on wrong PIN
advertencia  output  1  level: last attempt remaining
bloqueo  output  1  level: card locked
balance_actualizado  output  BALANCE_W  new balance (held between updates)
balance_stb  output  1  one-cycle pulse: balance_actualizado valid
entregar_dinero  output  1  one-cycle pulse: dispense cash
fondos_insuficientes  output  1  one-cycle pulse
limite_excedido  output  1  one-cycle pulse: daily limit would be exceeded
timeout  output  1  one-cycle pulse: session aborted on inactivity

Behaviour:
- Reset (async, any time, including mid-session): state = ESPERA_TARJETA; all outputs 0; attempt, digit, timeout and daily accumulators 0. All outputs are registered.
- States: ESPERA_TARJETA, ESPERA_PIN, ESPERA_MONTO, BLOQUEADO.
- ESPERA_TARJETA: tarjeta_recibida=1 -> ESPERA_PIN; clear the digit counter, PIN shift register and timeout counter. Strobes are ignored in this state.
- ESPERA_PIN: each digito_stb shifts digito into the LSB nibble and increments the digit counter. On the strobe that completes PIN_DIGITOS digits, compare the shifted value with pin_correcto; the result appears at the next edge.
  - Match -> ESPERA_MONTO; attempt counter cleared; advertencia cleared.
  - Mismatch -> attempt counter +1; pin_incorrecto pulses; digit counter cleared; stay in ESPERA_PIN.
  - Attempt counter reaches MAX_INTENTOS-1 -> advertencia = 1.
  - Attempt counter reaches MAX_INTENTOS -> BLOQUEADO; pin_incorrecto still pulses in that cycle.
- ESPERA_MONTO: on monto_stb, sample tipo_trans and monto (zero-extended to BALANCE_W). Outputs appear in the cycle after the strobe (latency 1), then the FSM returns to ESPERA_TARJETA.
  - Deposit: balance_actualizado = balance_inicial + monto, saturating at 2^BALANCE_W-1; balance_stb pulses.
  - Withdrawal, monto > balance_inicial: fondos_insuficientes pulses; balance unchanged; no balance_stb.
  - Withdrawal, accumulator + monto > LIMITE_DIARIO: limite_excedido pulses. Insufficient funds takes priority if both conditions hold.
  - Otherwise: balance_actualizado = balance_inicial - monto; balance_stb and entregar_dinero pulse in the same cycle; accumulator += monto.
  - monto = 0 is legal: deposit or withdrawal of 0 produces balance_stb (plus entregar_dinero for a withdrawal).
- Timeout: in ESPERA_PIN and ESPERA_MONTO the counter increments every cycle with no relevant strobe and clears on a strobe. When it reaches TIMEOUT_CICLOS: timeout pulses, state -> ESPERA_TARJETA, attempt counter and advertencia are cleared.
- BLOQUEADO: bloqueo = 1. All inputs except reset are ignored; only reset exits this state.
- dia_nuevo clears the accumulator in any state. If it coincides with a withdrawal commit, the accumulator becomes monto (the clear applies first).
- The accumulator is wide enough for LIMITE_DIARIO + 2^MONTO_W with no wrap.
- Strobes received in a state that does not expect them are ignored. tarjeta_recibida outside ESPERA_TARJETA is ignored.

Test Plan:
- PIN_DIGITOS=4, pin_correcto=16'h1234; insert card; digits 1,2,3,4 -> ESPERA_MONTO, no pin_incorrecto; deposit monto=500 with balance_inicial=1000 -> balance_actualizado=1500 and balance_stb for exactly 1 cycle, latency 1.
- Wrong PIN 1,2,3,5 three times with MAX_INTENTOS=3 -> pin_incorrecto pulse on each attempt; advertencia=1 after the 2nd attempt; bloqueo=1 after the 3rd; further card/digit activity has no effect; assert reset mid-lock -> all outputs 0.
- Withdrawal monto=2000, balance_inicial=1000 -> fondos_insuficientes pulse, no balance_stb or entregar_dinero; withdrawal monto=1000 -> balance_actualizado=0, entregar_dinero pulse.
- LIMITE_DIARIO=1000: withdraw 600 (ok), then 500 in a new session -> limite_excedido; pulse dia_nuevo, retry 500 -> entregar_dinero.
- TIMEOUT_CICLOS=10: insert card, enter 2 digits, then idle 10 cycles -> timeout pulse, back in ESPERA_TARJETA; a subsequent full correct PIN succeeds.
- BALANCE_W=8: deposit 10 onto 250 -> balance_actualizado=255 (saturated).
